// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - shares one single-ported memory between a data port (D) and a fetch port (I)
// D has fixed priority; I is forced through after STARVE_LIMIT consecutive losses.
module mem_port_arbiter #(
  parameter int ADDR_W       = 32,
  parameter int DATA_W       = 32,
  parameter int MEM_LAT      = 1,
  parameter int STARVE_LIMIT = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_gnt,
  output logic              d_rvalid,
  input  logic              i_req,
  input  logic [ADDR_W-1:0] i_addr,
  output logic              i_gnt,
  output logic              i_rvalid,
  output logic [DATA_W-1:0] rdata,
  output logic              sel,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;

  state_t     state;
  logic [3:0] starve_cnt;
  logic [3:0] lat_cnt;
  logic       i_wins;

  assign i_wins = i_req && (!d_req || (starve_cnt == 4'(STARVE_LIMIT)));

  // The registered mem_* fields double as the latched request of the current owner.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state      <= IDLE;
      sel        <= 1'b0;
      starve_cnt <= 4'd0;
      lat_cnt    <= 4'd0;
      d_gnt      <= 1'b0;
      i_gnt      <= 1'b0;
      d_rvalid   <= 1'b0;
      i_rvalid   <= 1'b0;
      rdata      <= '0;
      mem_en     <= 1'b0;
      mem_we     <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
    end else begin
      d_gnt     <= 1'b0;
      i_gnt     <= 1'b0;
      d_rvalid  <= 1'b0;
      i_rvalid  <= 1'b0;
      mem_en    <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      case (state)
        IDLE: begin
          if (d_req || i_req) begin
            state  <= ISSUE;
            sel    <= i_wins;
            mem_en <= 1'b1;
            d_gnt  <= !i_wins;
            i_gnt  <= i_wins;
            if (i_wins) begin
              mem_addr   <= i_addr;
              starve_cnt <= 4'd0;
            end else begin
              mem_we    <= d_we;
              mem_addr  <= d_addr;
              mem_wdata <= d_wdata;
              if (i_req && (starve_cnt != 4'(STARVE_LIMIT)))
                starve_cnt <= starve_cnt + 4'd1;
            end
          end
        end
        ISSUE: begin
          if (mem_we) begin
            state <= IDLE;
          end else begin
            state   <= WAIT;
            lat_cnt <= 4'(MEM_LAT);
          end
        end
        WAIT: begin
          if (lat_cnt == 4'd1) begin
            rdata    <= mem_rdata;
            state    <= DONE;
            d_rvalid <= !sel;
            i_rvalid <= sel;
          end else begin
            lat_cnt <= lat_cnt - 4'd1;
          end
        end
        DONE: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule
